// File: rtl/sm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sm_pkg
// Brief    : Shared op encoding and sign/magnitude slice helpers.
// Revision : 1.0 - initial release
// ============================================================================
package sm_pkg;

  typedef enum logic [1:0] {
    OP_ADD     = 2'b00,
    OP_SUB     = 2'b01,
    OP_ACC_ADD = 2'b10,
    OP_ACC_SUB = 2'b11
  } op_t;

  localparam int c_MAX_W = 64;

  // Helpers take a zero-extended word plus its real width.
  function automatic logic sm_sign(input logic [c_MAX_W-1:0] v, input int w);
    return v[w-1];
  endfunction

  function automatic logic [c_MAX_W-1:0] sm_mag(input logic [c_MAX_W-1:0] v, input int w);
    return v & ((c_MAX_W'(1) << (w - 1)) - c_MAX_W'(1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/sm_addsub.sv
`default_nettype none
// ============================================================================
// Module   : sm_addsub
// Brief    : Combinational sign-magnitude add/subtract with clamp or wrap.
// Revision : 1.0 - initial release
// ============================================================================
module sm_addsub
  import sm_pkg::*;
#(
  parameter int WIDTH    = 9,
  parameter bit SATURATE = 1'b1
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  localparam int c_MW = WIDTH - 1;
  localparam logic [c_MW-1:0] c_MAX = '1;

  logic [c_MW-1:0] w_xm, w_ym, w_sum_fix, w_mag;
  logic [c_MW:0]   w_sum;
  logic            w_xs, w_ys, w_rs;

  assign w_xm = (c_MW)'(sm_mag(c_MAX_W'(x), WIDTH));
  assign w_ym = (c_MW)'(sm_mag(c_MAX_W'(y), WIDTH));
  // Zero magnitudes get sign 0 so that -0 never steers the sign choice.
  assign w_xs = sm_sign(c_MAX_W'(x), WIDTH) & (|w_xm);
  assign w_ys = (sm_sign(c_MAX_W'(y), WIDTH) ^ sub) & (|w_ym);
  assign w_sum = {1'b0, w_xm} + {1'b0, w_ym};

  if (SATURATE) begin : g_sat
    assign w_sum_fix = w_sum[c_MW] ? c_MAX : w_sum[c_MW-1:0];
  end else begin : g_wrap
    assign w_sum_fix = w_sum[c_MW-1:0];
  end

  always_comb begin
    w_mag = '0;
    w_rs  = 1'b0;
    ovf   = 1'b0;
    if (w_xs == w_ys) begin
      w_mag = w_sum_fix;
      w_rs  = w_xs;
      ovf   = w_sum[c_MW];
    end else if (w_xm >= w_ym) begin
      w_mag = w_xm - w_ym;
      w_rs  = w_xs;
    end else begin
      w_mag = w_ym - w_xm;
      w_rs  = w_ys;
    end
    result = {w_rs & (|w_mag), w_mag};
  end

endmodule
`default_nettype wire

// File: rtl/sm_alu_acc.sv
`default_nettype none
// ============================================================================
// Module   : sm_alu_acc
// Brief    : Sign-magnitude ALU with accumulator, registered output, handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module sm_alu_acc
  import sm_pkg::*;
#(
  parameter int WIDTH    = 9,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] inputA,
  input  logic [WIDTH-1:0] inputB,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             overflow,
  output logic             ovf_sticky,
  output logic [WIDTH-1:0] acc
);

  logic [WIDTH-1:0] r_out, r_acc;
  logic             r_out_valid, r_ovf, r_sticky;
  logic [WIDTH-1:0] w_acc_eff, w_x, w_y, w_res;
  logic             w_xfer, w_is_acc, w_ovf;
  op_t              w_op;

  assign w_op     = op_t'(op);
  assign w_is_acc = (w_op == OP_ACC_ADD) || (w_op == OP_ACC_SUB);
  assign in_ready = !r_out_valid || out_ready;
  assign w_xfer   = in_valid && in_ready;

  // Clear takes effect before an accumulate in the same cycle.
  assign w_acc_eff = clear ? '0 : r_acc;
  assign w_x       = w_is_acc ? w_acc_eff : inputA;
  assign w_y       = w_is_acc ? inputA    : inputB;

  sm_addsub #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE)
  ) u_addsub (
    .x      (w_x),
    .y      (w_y),
    .sub    (op[0]),
    .result (w_res),
    .ovf    (w_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_acc       <= '0;
      r_sticky    <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_out       <= w_res;
        r_ovf       <= w_ovf;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (w_xfer && w_is_acc) begin
        r_acc <= w_res;
      end else if (clear) begin
        r_acc <= '0;
      end

      if (clear) begin
        r_sticky <= w_xfer && w_ovf;
      end else if (w_xfer && w_ovf) begin
        r_sticky <= 1'b1;
      end
    end
  end

  assign out        = r_out;
  assign overflow   = r_ovf;
  assign out_valid  = r_out_valid;
  assign ovf_sticky = r_sticky;
  assign acc        = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_sm_alu_acc.sv
`default_nettype none
// ============================================================================
// Module   : tb_sm_alu_acc
// Brief    : Directed checks of sm_alu_acc, saturating and wrapping variants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sm_alu_acc;

  localparam int c_W = 9;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b1;
  logic           clear = 1'b0;
  logic [1:0]     op = 2'b00;
  logic [c_W-1:0] inputA = '0;
  logic [c_W-1:0] inputB = '0;

  logic           s_in_ready, s_out_valid, s_overflow, s_sticky;
  logic [c_W-1:0] s_out, s_acc;
  logic           w_in_ready, w_out_valid, w_overflow, w_sticky;
  logic [c_W-1:0] w_out, w_acc;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sm_alu_acc #(.WIDTH(c_W), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .op(op),
    .inputA(inputA), .inputB(inputB), .clear(clear), .out_valid(s_out_valid),
    .out_ready(out_ready), .out(s_out), .overflow(s_overflow),
    .ovf_sticky(s_sticky), .acc(s_acc)
  );

  sm_alu_acc #(.WIDTH(c_W), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready), .op(op),
    .inputA(inputA), .inputB(inputB), .clear(clear), .out_valid(w_out_valid),
    .out_ready(out_ready), .out(w_out), .overflow(w_overflow),
    .ovf_sticky(w_sticky), .acc(w_acc)
  );

  task automatic chk(input string tag, input logic [c_W-1:0] got, input logic [c_W-1:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One transfer: drive at negedge, release one cycle later just after posedge.
  task automatic send(input logic [1:0] o, input logic [c_W-1:0] a,
                      input logic [c_W-1:0] b, input logic clr);
    @(negedge clk);
    in_valid = 1'b1; op = o; inputA = a; inputB = b; clear = clr;
    @(posedge clk); #1;
    in_valid = 1'b0; clear = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out", s_out, 9'h000);
    chk("rst_valid", 9'(s_out_valid), 9'h000);
    chk("rst_ovf", 9'(s_overflow), 9'h000);
    chk("rst_sticky", 9'(s_sticky), 9'h000);
    chk("rst_acc", s_acc, 9'h000);
    chk("rst_in_ready", 9'(s_in_ready), 9'h001);

    // Basic add/sub
    send(2'b00, 9'h003, 9'h102, 1'b0);
    chk("add_3_m2", s_out, 9'h001);
    chk("add_3_m2_ovf", 9'(s_overflow), 9'h000);
    chk("add_3_m2_valid", 9'(s_out_valid), 9'h001);
    chk("add_acc_untouched", s_acc, 9'h000);
    send(2'b01, 9'h103, 9'h102, 1'b0);
    chk("sub_m3_m2", s_out, 9'h101);
    send(2'b01, 9'h003, 9'h102, 1'b0);
    chk("sub_3_m2", s_out, 9'h005);

    // Zero results never carry a negative sign
    send(2'b00, 9'h005, 9'h105, 1'b0);
    chk("add_5_m5", s_out, 9'h000);
    send(2'b00, 9'h100, 9'h100, 1'b0);
    chk("add_negzero", s_out, 9'h000);
    @(posedge clk); #1;
    chk("valid_drops", 9'(s_out_valid), 9'h000);

    // Overflow, clamp vs wrap
    send(2'b00, 9'h0C8, 9'h064, 1'b0);
    chk("sat_pos", s_out, 9'h0FF);
    chk("sat_pos_ovf", 9'(s_overflow), 9'h001);
    chk("sat_pos_sticky", 9'(s_sticky), 9'h001);
    chk("wrap_pos", w_out, 9'h02C);
    chk("wrap_pos_ovf", 9'(w_overflow), 9'h001);
    send(2'b00, 9'h1C8, 9'h164, 1'b0);
    chk("sat_neg", s_out, 9'h1FF);
    chk("wrap_neg", w_out, 9'h12C);

    // Accumulate sequence after a standalone clear
    @(negedge clk); clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    chk("clear_sticky", 9'(s_sticky), 9'h000);
    chk("clear_acc", s_acc, 9'h000);
    send(2'b10, 9'h003, 9'h000, 1'b0);
    chk("acc_add_3", s_out, 9'h003);
    send(2'b10, 9'h105, 9'h000, 1'b0);
    chk("acc_add_m5", s_out, 9'h102);
    send(2'b11, 9'h101, 9'h000, 1'b0);
    chk("acc_sub_m1", s_out, 9'h101);
    chk("acc_end", s_acc, 9'h101);

    // Backpressure
    send(2'b10, 9'h005, 9'h000, 1'b1);
    chk("clr_acc_5", s_acc, 9'h005);
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; op = 2'b10; inputA = 9'h002;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_in_ready", 9'(s_in_ready), 9'h000);
      chk("bp_out_hold", s_out, 9'h005);
      chk("bp_acc_hold", s_acc, 9'h005);
    end
    @(negedge clk); out_ready = 1'b1; #1;
    chk("bp_ready_comb", 9'(s_in_ready), 9'h001);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_resume_out", s_out, 9'h007);
    chk("bp_resume_acc", s_acc, 9'h007);
    chk("bp_resume_valid", 9'(s_out_valid), 9'h001);

    // Reset discards held output and accumulator
    send(2'b00, 9'h0C8, 9'h064, 1'b0);
    send(2'b11, 9'h002, 9'h000, 1'b0);
    chk("pre_rst_acc", s_acc, 9'h005);
    chk("pre_rst_sticky", 9'(s_sticky), 9'h001);
    @(negedge clk); rst = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1; rst = 1'b0; out_ready = 1'b1;
    chk("mid_rst_valid", 9'(s_out_valid), 9'h000);
    chk("mid_rst_acc", s_acc, 9'h000);
    chk("mid_rst_sticky", 9'(s_sticky), 9'h000);

    // Clear coincident with accumulate
    send(2'b10, 9'h003, 9'h000, 1'b0);
    send(2'b10, 9'h007, 9'h000, 1'b1);
    chk("clr_acc_add_7", s_acc, 9'h007);
    chk("clr_acc_add_7_out", s_out, 9'h007);
    send(2'b10, 9'h0FF, 9'h000, 1'b1);
    chk("acc_max", s_acc, 9'h0FF);
    send(2'b10, 9'h001, 9'h000, 1'b0);
    chk("acc_sat", s_acc, 9'h0FF);
    chk("acc_sat_ovf", 9'(s_overflow), 9'h001);
    chk("acc_sat_sticky", 9'(s_sticky), 9'h001);
    chk("acc_wrap_zero", w_out, 9'h000);
    chk("acc_wrap_ovf", 9'(w_overflow), 9'h001);

    // Clear while stalled
    @(negedge clk); out_ready = 1'b0; clear = 1'b1;
    @(posedge clk); #1; clear = 1'b0;
    chk("stall_clr_acc", s_acc, 9'h000);
    chk("stall_clr_sticky", 9'(s_sticky), 9'h000);
    chk("stall_clr_out", s_out, 9'h0FF);
    chk("stall_clr_valid", 9'(s_out_valid), 9'h001);
    out_ready = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
